// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by both the transmit-side generator and the
// receive-side checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Default polynomial x^9 + x^5 + 1.
  localparam int PRBS_POLY_LENGTH = 9;
  localparam int PRBS_POLY_TAP    = 5;

  // Bits needed for a counter that must hold the value max_count.
  function automatic int ctr_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_to_para.sv
// Word deserialiser: shifts in one bit per enabled cycle, first bit lands in
// the word MSB. Dropping enable discards any partial word.
module serial_to_para
  import prbs_pkg::*;
#(
  parameter int WORD_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_i,
  input  logic                  enable_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o
);

  localparam int CW = ctr_width(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  // Next-state: accumulate bits while enabled, publish on the last bit.
  always_comb begin
    shift_d = {shift_q[WORD_WIDTH-2:0], bit_i};
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (!enable_i) begin
      shift_d = shift_q;
      cnt_d   = '0;
    end else if (cnt_q == CW'(WORD_WIDTH - 1)) begin
      cnt_d   = '0;
      word_d  = shift_d;
      valid_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prbs_rx_checker.sv
// Self-synchronising PRBS receive checker: locks onto the de-inverted serial
// pattern, flags/counts bit errors and deserialises locked data into words.
module prbs_rx_checker
  import prbs_pkg::*;
#(
  parameter int POLY_LENGTH   = PRBS_POLY_LENGTH,
  parameter int POLY_TAP      = PRBS_POLY_TAP,
  parameter int INV_PATTERN   = 1,
  parameter int WORD_WIDTH    = 10,
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_ERRS   = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     err_clr,
  output logic                     lock,
  output logic                     bit_err,
  output logic [ERR_CNT_WIDTH-1:0] bit_err_cnt,
  output logic [WORD_WIDTH-1:0]    data_out,
  output logic                     data_valid
);

  localparam int FILL_W  = ctr_width(POLY_LENGTH - 1);
  localparam int MATCH_W = ctr_width(LOCK_COUNT - 1);
  localparam int WIN_W   = ctr_width(UNLOCK_WINDOW - 1);
  localparam int WERR_W  = ctr_width(UNLOCK_ERRS - 1);

  prbs_state_e              state_q;
  logic [POLY_LENGTH-1:0]   hist_q;
  logic [FILL_W-1:0]        fill_q;
  logic [MATCH_W-1:0]       match_q;
  logic [WIN_W-1:0]         win_q;
  logic [WERR_W-1:0]        werr_q;
  logic                     lock_q;
  logic                     bit_err_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic b_s;
  logic expected_s;
  logic mismatch_s;

  assign b_s        = serial_in ^ 1'(INV_PATTERN);
  assign expected_s = hist_q[POLY_LENGTH-1] ^ hist_q[POLY_TAP-1];
  // An all-zero history is never a legal PRBS state, so a stuck line never locks.
  assign mismatch_s = (b_s != expected_s) || (hist_q == '0);

  // Checker FSM with history shift, lock/loss-of-lock counters and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      lock_q    <= 1'b0;
      bit_err_q <= 1'b0;
    end else begin
      hist_q    <= {hist_q[POLY_LENGTH-2:0], b_s};
      bit_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (fill_q == FILL_W'(POLY_LENGTH - 1)) begin
            state_q <= SEARCH;
            match_q <= '0;
          end else begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        SEARCH: begin
          if (mismatch_s) begin
            match_q <= '0;
          end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
            state_q <= LOCKED;
            lock_q  <= 1'b1;
            win_q   <= '0;
            werr_q  <= '0;
          end else begin
            match_q <= match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          bit_err_q <= mismatch_s;
          // Reaching the error limit takes precedence over the window wrap.
          if (mismatch_s && (werr_q == WERR_W'(UNLOCK_ERRS - 1))) begin
            state_q <= SEARCH;
            lock_q  <= 1'b0;
            match_q <= '0;
          end else if (win_q == WIN_W'(UNLOCK_WINDOW - 1)) begin
            win_q  <= '0;
            werr_q <= '0;
          end else begin
            win_q <= win_q + WIN_W'(1);
            if (mismatch_s) begin
              werr_q <= werr_q + WERR_W'(1);
            end
          end
        end
        default: begin
          state_q <= FILL;
          fill_q  <= '0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear wins over a same-cycle error.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if ((state_q == LOCKED) && mismatch_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Error counter register; survives loss of lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  serial_to_para #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serial_to_para (
    .clk      (clk),
    .rst      (rst),
    .bit_i    (b_s),
    .enable_i (state_q == LOCKED),
    .word_o   (data_out),
    .valid_o  (data_valid)
  );

  assign lock        = lock_q;
  assign bit_err     = bit_err_q;
  assign bit_err_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Scoreboard bench for prbs_rx_checker: a stream-level reference model queues
// expected words, error pulses and lock edges; a monitor consumes them.
module tb_prbs_rx_checker;

  localparam int WW = 10;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic err_clr;

  logic        lock1, be1, dv1;
  logic [15:0] cnt1;
  logic [9:0]  do1;
  logic        lock2, be2, dv2;
  logic [3:0]  cnt2;
  logic [9:0]  do2;

  always #5 clk = ~clk;

  prbs_rx_checker u_dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .err_clr(err_clr),
    .lock(lock1), .bit_err(be1), .bit_err_cnt(cnt1), .data_out(do1), .data_valid(dv1)
  );

  prbs_rx_checker #(.ERR_CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .err_clr(err_clr),
    .lock(lock2), .bit_err(be2), .bit_err_cnt(cnt2), .data_out(do2), .data_valid(dv2)
  );

  typedef struct { int seq; logic [9:0] word; } word_t;
  typedef struct { int seq; bit val; } lock_t;

  word_t exp_words[$];
  int    exp_errs[$];
  lock_t exp_locks[$];

  int n_cmp = 0;
  int n_bad = 0;
  int drv_seq = 0;
  int first_lock_seq = 0;
  int first_valid_seq = 0;

  // Reference model state (stream level).
  int         m_mode;
  int         m_nfill, m_nmatch, m_wbits, m_werrs, m_wn;
  int         m_cnt16, m_cnt4;
  bit         m_hist[$];
  logic [9:0] m_wacc;
  logic [8:0] tx_lfsr = 9'h1FF;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic next_tx(output bit o);
    o = tx_lfsr[8];
    tx_lfsr = {tx_lfsr[7:0], tx_lfsr[8] ^ tx_lfsr[4]};
  endtask

  task automatic model_reset();
    m_mode = 0; m_nfill = 0; m_nmatch = 0; m_wbits = 0; m_werrs = 0; m_wn = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_wacc = '0;
    m_hist.delete();
    drv_seq = 0; first_lock_seq = 0; first_valid_seq = 0;
  endtask

  // mode 0 = filling history, 1 = searching, 2 = locked
  task automatic model_step(input bit b, input bit clr);
    bit bad;
    bit allz;
    int n;
    bad = 1'b0;
    if (m_mode != 0) begin
      n = m_hist.size();
      allz = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) allz = 1'b0;
      bad = allz || (b != (m_hist[n-9] ^ m_hist[n-5]));
    end
    if (m_mode == 2) begin
      m_wacc = {m_wacc[8:0], b};
      m_wn++;
      if (m_wn == WW) begin
        exp_words.push_back('{seq: drv_seq, word: m_wacc});
        m_wn = 0;
      end
    end
    if (clr) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (m_mode == 2 && bad) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    case (m_mode)
      0: begin
        m_nfill++;
        if (m_nfill == 9) begin m_mode = 1; m_nmatch = 0; end
      end
      1: begin
        if (bad) m_nmatch = 0;
        else begin
          m_nmatch++;
          if (m_nmatch == 32) begin
            m_mode = 2; m_wbits = 0; m_werrs = 0; m_wn = 0;
            exp_locks.push_back('{seq: drv_seq, val: 1'b1});
          end
        end
      end
      default: begin
        m_wbits++;
        if (bad) begin
          exp_errs.push_back(drv_seq);
          m_werrs++;
        end
        if (m_werrs == 8) begin
          m_mode = 1; m_nmatch = 0;
          exp_locks.push_back('{seq: drv_seq, val: 1'b0});
        end else if (m_wbits == 64) begin
          m_wbits = 0; m_werrs = 0;
        end
      end
    endcase
    m_hist.push_back(b);
    if (m_hist.size() > 9) void'(m_hist.pop_front());
  endtask

  // b is the de-inverted (transmitted PRBS) bit; the line carries its inverse.
  task automatic send_bit(input bit b, input bit clr);
    @(negedge clk);
    #1;
    serial_in = ~b;
    err_clr = clr;
    drv_seq++;
    model_step(b, clr);
  endtask

  task automatic send_prbs(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      next_tx(b);
      send_bit(b, 1'b0);
    end
  endtask

  task automatic send_flip(input bit clr);
    bit b;
    next_tx(b);
    send_bit(~b, clr);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_lock"}, {31'd0, lock1}, 32'd0);
    check({tag, "_bit_err"}, {31'd0, be1}, 32'd0);
    check({tag, "_cnt"}, {16'd0, cnt1}, 32'd0);
    check({tag, "_cnt4"}, {28'd0, cnt2}, 32'd0);
    check({tag, "_data_out"}, {22'd0, do1}, 32'd0);
    check({tag, "_data_valid"}, {31'd0, dv1}, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs(tag);
    repeat (3) @(posedge clk);
    release_reset();
  endtask

  // Monitor: pops expectations whenever either DUT presents an event.
  initial begin : monitor
    logic p1, p2;
    word_t ew;
    lock_t el;
    int es;
    p1 = 1'b0; p2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (dv1 || dv2) begin
          n_cmp++;
          if (exp_words.size() == 0) begin
            n_bad++;
            $display("FAIL word: unexpected data_valid %b/%b at bit %0d", dv1, dv2, drv_seq);
          end else begin
            ew = exp_words.pop_front();
            if (!(dv1 && dv2 && ew.seq == drv_seq && do1 === ew.word && do2 === ew.word)) begin
              n_bad++;
              $display("FAIL word: valid %b/%b data %h/%h at bit %0d, want %h at bit %0d",
                       dv1, dv2, do1, do2, drv_seq, ew.word, ew.seq);
            end
          end
          if (first_valid_seq == 0) first_valid_seq = drv_seq;
        end
        if (be1 || be2) begin
          n_cmp++;
          if (exp_errs.size() == 0) begin
            n_bad++;
            $display("FAIL bit_err: unexpected pulse %b/%b at bit %0d", be1, be2, drv_seq);
          end else begin
            es = exp_errs.pop_front();
            if (!(be1 && be2 && es == drv_seq)) begin
              n_bad++;
              $display("FAIL bit_err: pulse %b/%b at bit %0d, want both at bit %0d", be1, be2, drv_seq, es);
            end
          end
        end
        if (lock1 !== p1 || lock2 !== p2) begin
          n_cmp++;
          if (exp_locks.size() == 0) begin
            n_bad++;
            $display("FAIL lock: unexpected change to %b/%b at bit %0d", lock1, lock2, drv_seq);
          end else begin
            el = exp_locks.pop_front();
            if (!(lock1 === el.val && lock2 === el.val && el.seq == drv_seq)) begin
              n_bad++;
              $display("FAIL lock: %b/%b at bit %0d, want %b at bit %0d", lock1, lock2, drv_seq, el.val, el.seq);
            end
          end
          if (lock1 === 1'b1 && first_lock_seq == 0) first_lock_seq = drv_seq;
        end
      end
      p1 = lock1;
      p2 = lock2;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    rst = 1'b0;
    serial_in = 1'b1;
    err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    release_reset();

    // Clean stream: lock after bit 41, first word at bit 51.
    send_prbs(120);
    settle();
    check("lock_bit", first_lock_seq, 32'd41);
    check("first_valid_bit", first_valid_seq, 32'd51);
    check("clean_lock", {31'd0, lock1}, 32'd1);
    check("clean_cnt", {16'd0, cnt1}, 32'd0);

    // Isolated line errors: three pulses each, lock held.
    for (int f = 0; f < 7; f++) begin
      send_prbs(20);
      send_flip(1'b0);
      send_prbs(49);
      settle();
      check("flip_cnt", {16'd0, cnt1}, 32'(3 * (f + 1)));
      check("flip_cnt4", {28'd0, cnt2}, 32'(m_cnt4));
      check("flip_lock", {31'd0, lock1}, 32'd1);
    end
    check("sat_cnt4", {28'd0, cnt2}, 32'd15);

    // Clear on the same bit as an error drops that error.
    send_prbs(20);
    send_flip(1'b1);
    settle();
    check("clr_cnt", {16'd0, cnt1}, 32'd0);
    check("clr_cnt4", {28'd0, cnt2}, 32'd0);
    send_prbs(49);
    settle();
    check("after_clr_cnt", {16'd0, cnt1}, 32'd2);

    // Random data forces loss of lock; PRBS resumption relocks without refill.
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    settle();
    check("random_lock", {31'd0, lock1}, 32'd0);
    check("random_cnt", {16'd0, cnt1}, 32'(m_cnt16));
    check("random_cnt4", {28'd0, cnt2}, 32'(m_cnt4));
    send_prbs(41);
    settle();
    check("relock", {31'd0, lock1}, 32'd1);

    // Reset mid-word while locked.
    send_prbs(3);
    do_reset("midreset");
    send_prbs(60);
    settle();
    check("relock_bit", first_lock_seq, 32'd41);
    check("relock_lock", {31'd0, lock1}, 32'd1);

    // Stuck line (de-inverted zeros) never locks.
    do_reset("stuckreset");
    for (int i = 0; i < 1000; i++) send_bit(1'b0, 1'b0);
    settle();
    check("stuck_lock", {31'd0, lock1}, 32'd0);
    check("stuck_cnt", {16'd0, cnt1}, 32'd0);
    check("stuck_never_locked", first_lock_seq, 32'd0);

    check("words_pending", exp_words.size(), 32'd0);
    check("errs_pending", exp_errs.size(), 32'd0);
    check("locks_pending", exp_locks.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
